// File: rtl/udma_l2_rd_arbiter_pkg.sv
// Shared types for the uDMA L2 read arbiter: datasize encoding, return tag and defaults.
// Tags travel through the in-order ID FIFO and steer returning data to its owner.
package udma_l2_rd_arbiter_pkg;

    localparam int unsigned L2_AWIDTH_NOAL    = 19;
    localparam int unsigned UDMA_RD_MAX_OUTST = 2;
    // Tag ID field is fixed-width so the struct stays parameter-free; supports up to 16 channels.
    localparam int unsigned UDMA_RD_ID_W      = 4;

    typedef enum logic [1:0] {
        RdByte = 2'd0,
        RdHalf = 2'd1,
        RdWord = 2'd2
    } udma_rd_size_e;

    typedef struct packed {
        logic [UDMA_RD_ID_W-1:0] id;
        logic [1:0]              offset;
        udma_rd_size_e           size;
    } udma_rd_tag_t;

    // Encoding 3 is not a legal size and is handled as a full word.
    function automatic udma_rd_size_e rd_size_from_bits(logic [1:0] ds);
        case (ds)
            2'd0:    return RdByte;
            2'd1:    return RdHalf;
            default: return RdWord;
        endcase
    endfunction

endpackage

// File: rtl/udma_l2_rd_arbiter_if.sv
// TX-side L2 read port: request/grant with address, later rvalid/rdata.
// The arbiter drives it through the master modport; the L2 side uses slave.
interface udma_l2_rd_arbiter_if #(
    parameter int unsigned DATA_W = 32
) ();
    logic              req;
    logic              gnt;
    logic [31:0]       addr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output req, output addr, input gnt, input rdata, input rvalid);
    modport slave  (input req, input addr, output gnt, output rdata, output rvalid);
endinterface

// File: rtl/udma_rd_tag_fifo.sv
// Small synchronous FIFO of arbitrary entry type with occupancy count.
// Push and pop in the same cycle are both honoured; push when full and pop when empty are dropped.
module udma_rd_tag_fifo #(
    parameter int unsigned  Depth = 2,
    parameter type          T     = logic,
    localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1,
    localparam int unsigned CntW  = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            push_i,
    input  T                data_i,
    input  logic            pop_i,
    output T                data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [CntW-1:0] count_o
);

    T                mem_q [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] next_ptr(logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_comb begin
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CntW'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/udma_l2_rd_arbiter.sv
// Round-robin share of the TX L2 read port among N_CH requesters, with a lock across stalled
// requests and in-order routing of returned words to their owner, aligned and zero-extended.
module udma_l2_rd_arbiter
    import udma_l2_rd_arbiter_pkg::*;
#(
    parameter int unsigned  N_CH      = 4,
    parameter int unsigned  ADDR_W    = L2_AWIDTH_NOAL,
    parameter int unsigned  DATA_W    = 32,
    parameter int unsigned  MAX_OUTST = UDMA_RD_MAX_OUTST,
    localparam int unsigned ID_W      = $clog2(N_CH),
    localparam int unsigned CntW      = $clog2(MAX_OUTST + 1)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [N_CH-1:0]              ch_req_i,
    input  logic [N_CH-1:0][ADDR_W-1:0]  ch_addr_i,
    input  logic [N_CH-1:0][1:0]         ch_datasize_i,
    output logic [N_CH-1:0]              ch_gnt_o,
    output logic [N_CH-1:0]              ch_valid_o,
    output logic [DATA_W-1:0]            ch_data_o,
    udma_l2_rd_arbiter_if.master         l2_io,
    input  logic [31-ADDR_W:0]           l2_src_i,
    output logic                         busy_o,
    output logic                         err_o
);

    logic [ID_W-1:0]   ptr_q, ptr_d, lock_id_q, lock_id_d;
    logic [ID_W-1:0]   rr_id, cand, win_id;
    logic              lock_q, lock_d, err_q, err_d;
    logic              rr_found, lock_hold, lock_drop;
    logic              l2_req, grant, pop, stray;
    logic              fifo_full, fifo_empty;
    logic [CntW-1:0]   fifo_count;
    udma_rd_tag_t      push_tag, head_tag;
    logic [DATA_W-1:0] shifted, mask;

    // First requester after the last winner, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_id    = ptr_q;
        cand     = ptr_q;
        for (int unsigned i = 1; i <= N_CH; i++) begin
            cand = ID_W'((32'(ptr_q) + i) % N_CH);
            if (!rr_found && ch_req_i[cand]) begin
                rr_found = 1'b1;
                rr_id    = cand;
            end
        end
    end

    // A lock whose owner withdrew is abandoned at once so no one else is granted in its name.
    assign lock_hold = lock_q & ch_req_i[lock_id_q];
    assign lock_drop = lock_q & ~ch_req_i[lock_id_q];
    assign win_id    = lock_hold ? lock_id_q : rr_id;

    assign l2_req     = (|ch_req_i) & ~fifo_full;
    assign grant      = l2_req & l2_io.gnt;
    assign l2_io.req  = l2_req;
    assign l2_io.addr = l2_req ? {l2_src_i, ch_addr_i[win_id][ADDR_W-1:2], 2'b00} : 32'h0;
    assign ch_gnt_o   = grant ? (N_CH'(1) << win_id) : '0;

    assign push_tag.id     = UDMA_RD_ID_W'(win_id);
    assign push_tag.offset = ch_addr_i[win_id][1:0];
    assign push_tag.size   = rd_size_from_bits(ch_datasize_i[win_id]);

    udma_rd_tag_fifo #(
        .Depth (MAX_OUTST),
        .T     (udma_rd_tag_t)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (grant),
        .data_i  (push_tag),
        .pop_i   (pop),
        .data_o  (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign pop   = l2_io.rvalid & ~fifo_empty;
    assign stray = l2_io.rvalid & fifo_empty;

    always_comb begin
        shifted = l2_io.rdata >> {head_tag.offset, 3'b000};
        case (head_tag.size)
            RdByte:  mask = DATA_W'(8'hFF);
            RdHalf:  mask = DATA_W'(16'hFFFF);
            default: mask = '1;
        endcase
    end

    assign ch_valid_o = pop ? (N_CH'(1) << head_tag.id) : '0;
    assign ch_data_o  = pop ? (shifted & mask) : '0;
    assign busy_o     = (fifo_count != '0);
    assign err_o      = err_q;

    always_comb begin
        ptr_d     = ptr_q;
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        err_d     = err_q | lock_drop | stray;
        if (grant) begin
            ptr_d  = win_id;
            lock_d = 1'b0;
        end else begin
            lock_d    = l2_req;
            lock_id_d = win_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q     <= ID_W'(N_CH - 1);
            lock_q    <= 1'b0;
            lock_id_q <= '0;
            err_q     <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
            err_q     <= err_d;
        end
    end

endmodule
